// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared AXI constants, FSM encodings and line-offset helper for the cache AXI bridge
package cache_axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    function automatic int line_off(input int line_words);
        return $clog2(line_words) + 2;
    endfunction
endpackage

// File: rtl/cache_axi_rd_buf.sv
// cache_axi_rd_buf: per-client R-beat assembly, error flag, outstanding flag and completion pulse
module cache_axi_rd_buf #(
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     accept,
    input  logic                     beat,
    input  logic                     last,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    output logic                     outstanding,
    output logic                     ret_valid,
    output logic                     ret_err,
    output logic [LINE_WORDS*32-1:0] ret_data
);
    localparam int CW = $clog2(LINE_WORDS);
    logic [CW-1:0] rcount;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rcount      <= '0;
            outstanding <= 1'b0;
            ret_valid   <= 1'b0;
            ret_err     <= 1'b0;
            ret_data    <= '0;
        end else begin
            ret_valid <= beat & last;
            if (accept) begin
                outstanding <= 1'b1;
                ret_err     <= 1'b0;
            end
            if (beat) begin
                ret_data[{rcount, 5'd0} +: 32] <= rdata;
                ret_err <= ret_err | (rresp != 2'b00);
                rcount  <= last ? '0 : rcount + 1'b1;
                if (last) outstanding <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: NPORT read clients and one write client onto a single AXI3 master port
module cache_axi_bridge
    import cache_axi_pkg::*;
#(
    parameter int NPORT      = 2,
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NPORT-1:0]              rd_req,
    input  logic [NPORT-1:0]              rd_type,
    input  logic [NPORT*32-1:0]           rd_addr,
    input  logic [NPORT*3-1:0]            rd_size,
    output logic [NPORT-1:0]              rd_rdy,
    output logic [NPORT-1:0]              ret_valid,
    output logic [NPORT-1:0]              ret_err,
    output logic [NPORT*LINE_WORDS*32-1:0] ret_data,
    input  logic                          wr_req,
    input  logic                          wr_type,
    input  logic [31:0]                   wr_addr,
    input  logic [2:0]                    wr_size,
    input  logic [3:0]                    wr_wstrb,
    input  logic [LINE_WORDS*32-1:0]      wr_data,
    output logic                          wr_rdy,
    output logic                          wr_ok,
    output logic [3:0]                    axi_arid,
    output logic [31:0]                   axi_araddr,
    output logic [7:0]                    axi_arlen,
    output logic [2:0]                    axi_arsize,
    output logic [1:0]                    axi_arburst,
    output logic [1:0]                    axi_arlock,
    output logic [3:0]                    axi_arcache,
    output logic [2:0]                    axi_arprot,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    input  logic [3:0]                    axi_rid,
    input  logic [31:0]                   axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic                          axi_rlast,
    input  logic                          axi_rvalid,
    output logic                          axi_rready,
    output logic [3:0]                    axi_awid,
    output logic [31:0]                   axi_awaddr,
    output logic [7:0]                    axi_awlen,
    output logic [2:0]                    axi_awsize,
    output logic [1:0]                    axi_awburst,
    output logic [1:0]                    axi_awlock,
    output logic [3:0]                    axi_awcache,
    output logic [2:0]                    axi_awprot,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [3:0]                    axi_wid,
    output logic [31:0]                   axi_wdata,
    output logic [3:0]                    axi_wstrb,
    output logic                          axi_wlast,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [3:0]                    axi_bid,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready
);
    localparam int LO = line_off(LINE_WORDS);
    localparam int CW = $clog2(LINE_WORDS);
    ar_state_t ar_state, ar_next;
    wr_state_t wr_state, wr_next;
    logic [NPORT-1:0] outstanding, hazard, eligible, beat, accept;
    logic [1:0] sel;
    logic blocked;
    logic aw_pend, w_pend, aw_hs, w_hs, wr_done;
    logic [7:0] wcount;
    logic [LINE_WORDS*32-1:0] wr_data_q;
    logic unused_b;

    assign unused_b = ^{axi_bid, axi_bresp};
    assign axi_arburst = AXI_BURST_INCR;
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_arlock  = 2'b00;
    assign axi_awlock  = 2'b00;
    assign axi_arcache = 4'h0;
    assign axi_awcache = 4'h0;
    assign axi_arprot  = 3'h0;
    assign axi_awprot  = 3'h0;
    assign axi_awid    = 4'(NPORT);
    assign axi_wid     = 4'(NPORT);
    assign axi_rready  = 1'b1;

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        // Line-granular compare against the write still in flight
        assign hazard[i]   = (wr_state != WR_IDLE) && (rd_addr[32*i+LO +: 32-LO] == axi_awaddr[31:LO]);
        assign eligible[i] = (ar_state == AR_IDLE) && !outstanding[i] && !hazard[i];
        assign beat[i]     = axi_rvalid && (axi_rid == 4'(i));
        cache_axi_rd_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
            .clk        (clk),
            .resetn     (resetn),
            .accept     (accept[i]),
            .beat       (beat[i]),
            .last       (axi_rlast),
            .rdata      (axi_rdata),
            .rresp      (axi_rresp),
            .outstanding(outstanding[i]),
            .ret_valid  (ret_valid[i]),
            .ret_err    (ret_err[i]),
            .ret_data   (ret_data[i*LINE_WORDS*32 +: LINE_WORDS*32])
        );
    end

    always_comb begin
        rd_rdy  = '0;
        sel     = '0;
        blocked = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            rd_rdy[i] = eligible[i] & ~blocked;
            if (rd_req[i] & eligible[i] & ~blocked) sel = 2'(i);
            blocked = blocked | (rd_req[i] & eligible[i]);
        end
    end

    assign accept      = rd_req & rd_rdy;
    assign axi_arvalid = (ar_state == AR_SEND);
    always_comb ar_next = (ar_state == AR_IDLE) ? ((|accept) ? AR_SEND : AR_IDLE)
                                                : (axi_arready ? AR_IDLE : AR_SEND);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state   <= AR_IDLE;
            axi_arid   <= '0;
            axi_araddr <= '0;
            axi_arlen  <= '0;
            axi_arsize <= '0;
        end else begin
            ar_state <= ar_next;
            if (|accept) begin
                axi_arid   <= 4'(sel);
                axi_araddr <= rd_addr[32*sel +: 32];
                axi_arlen  <= rd_type[sel] ? 8'(LINE_WORDS-1) : 8'd0;
                axi_arsize <= rd_type[sel] ? AXI_SIZE_WORD : rd_size[3*sel +: 3];
            end
        end
    end

    always_comb begin
        wr_rdy      = (wr_state == WR_IDLE);
        axi_awvalid = (wr_state == WR_DATA) & aw_pend;
        axi_wvalid  = (wr_state == WR_DATA) & w_pend;
        axi_bready  = (wr_state == WR_RESP);
        axi_wlast   = axi_wvalid & (wcount == axi_awlen);
        axi_wdata   = wr_data_q[{wcount[CW-1:0], 5'd0} +: 32];
        aw_hs       = axi_awvalid & axi_awready;
        w_hs        = axi_wvalid & axi_wready;
        wr_done     = !(aw_pend & ~aw_hs) && !(w_pend & ~(w_hs & axi_wlast));
        wr_next     = (wr_state == WR_IDLE) ? (wr_req ? WR_DATA : WR_IDLE)
                    : (wr_state == WR_DATA) ? (wr_done ? WR_RESP : WR_DATA)
                    : (axi_bvalid ? WR_IDLE : WR_RESP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state   <= WR_IDLE;
            wr_ok      <= 1'b0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            wcount     <= '0;
            axi_awaddr <= '0;
            axi_awlen  <= '0;
            axi_awsize <= '0;
            axi_wstrb  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_state <= wr_next;
            wr_ok    <= axi_bready & axi_bvalid;
            if (wr_req && wr_rdy) begin
                aw_pend    <= 1'b1;
                w_pend     <= 1'b1;
                wcount     <= '0;
                axi_awaddr <= wr_addr;
                axi_awlen  <= wr_type ? 8'(LINE_WORDS-1) : 8'd0;
                axi_awsize <= wr_type ? AXI_SIZE_WORD : wr_size;
                axi_wstrb  <= wr_type ? 4'hF : wr_wstrb;
                wr_data_q  <= wr_data;
            end else begin
                if (aw_hs) aw_pend <= 1'b0;
                if (w_hs) begin
                    wcount <= wcount + 8'd1;
                    if (axi_wlast) w_pend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: directed self-checking bench for cache_axi_bridge (NPORT=2, LINE_WORDS=8)
module tb_cache_axi_bridge;
    localparam int NPORT = 2;
    localparam int LW    = 8;

    logic clk = 1'b0;
    logic resetn;
    logic [NPORT-1:0] rd_req, rd_type, rd_rdy, ret_valid, ret_err;
    logic [NPORT*32-1:0] rd_addr;
    logic [NPORT*3-1:0] rd_size;
    logic [NPORT*LW*32-1:0] ret_data;
    logic wr_req, wr_type, wr_rdy, wr_ok;
    logic [31:0] wr_addr;
    logic [2:0] wr_size;
    logic [3:0] wr_wstrb;
    logic [LW*32-1:0] wr_data;
    logic [3:0] axi_arid, axi_rid, axi_awid, axi_wid, axi_bid, axi_arcache, axi_awcache, axi_wstrb;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic [7:0] axi_arlen, axi_awlen;
    logic [2:0] axi_arsize, axi_awsize, axi_arprot, axi_awprot;
    logic [1:0] axi_arburst, axi_arlock, axi_rresp, axi_awburst, axi_awlock, axi_bresp;
    logic axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
    logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp0, exp1;

    cache_axi_bridge #(.NPORT(NPORT), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_size(rd_size),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_err(ret_err), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_size(wr_size),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_ok(wr_ok),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd_issue(input int p, input logic t, input logic [31:0] a, input logic [2:0] s);
        rd_type[p] = t;
        rd_addr[32*p +: 32] = a;
        rd_size[3*p +: 3] = s;
        rd_req = '0;
        rd_req[p] = 1'b1;
        #1;
        check("issue_rdy", rd_rdy[p], 1'b1);
        tick();
        rd_req = '0;
        check("issue_arvalid", axi_arvalid, 1'b1);
        check("issue_arid", axi_arid, 4'(p));
        check("issue_araddr", axi_araddr, a);
        check("issue_arlen", axi_arlen, t ? 8'd7 : 8'd0);
        check("issue_arsize", axi_arsize, t ? 3'd2 : s);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
    endtask

    task automatic r_beat(input int id, input logic [31:0] d, input logic [1:0] resp, input logic last);
        axi_rvalid = 1'b1;
        axi_rid    = 4'(id);
        axi_rdata  = d;
        axi_rresp  = resp;
        axi_rlast  = last;
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        rd_req = '0; rd_type = '0; rd_addr = '0; rd_size = '0;
        wr_req = 1'b0; wr_type = 1'b0; wr_addr = '0; wr_size = '0; wr_wstrb = '0; wr_data = '0;
        axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
        axi_rvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0; axi_bid = '0; axi_bresp = '0;
        axi_bvalid = 1'b0;
        repeat (2) tick();
        check("rst_wr_rdy", wr_rdy, 1'b1);
        check("rst_rd_rdy", rd_rdy, 2'b11);
        check("rst_outputs", {axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, wr_ok, ret_valid, ret_err}, '0);
        check("rst_consts", {axi_arburst, axi_awid, axi_wid, axi_rready}, {2'b01, 4'd2, 4'd2, 1'b1});
        resetn = 1'b1;
        tick();

        // Client 1 line read
        rd_issue(1, 1'b1, 32'h1000, 3'd0);
        check("line_rd_rdy_busy", rd_rdy[1], 1'b0);
        for (int k = 0; k < LW; k++) r_beat(1, 32'hA0 + k, 2'b00, k == LW-1);
        for (int k = 0; k < LW; k++) exp1[32*k +: 32] = 32'hA0 + k;
        check("line_ret_valid", ret_valid, 2'b10);
        check("line_ret_err", ret_err, 2'b00);
        check("line_ret_data", ret_data[256 +: 256], exp1);
        check("line_rd_rdy_back", rd_rdy[1], 1'b1);
        tick();
        check("line_ret_valid_pulse", ret_valid, 2'b00);

        // Simultaneous requests: client 0 wins
        rd_type = 2'b11;
        rd_addr = {32'h140, 32'h100};
        rd_req  = 2'b11;
        #1;
        check("prio_rd_rdy", rd_rdy, 2'b01);
        tick();
        rd_req = 2'b10;
        #1;
        check("prio_arid0", axi_arid, 4'd0);
        check("prio_slot_busy", rd_rdy, 2'b00);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        #1;
        check("prio_rd_rdy_c1", rd_rdy, 2'b10);
        tick();
        rd_req = 2'b00;
        check("prio_arid1", axi_arid, 4'd1);
        check("prio_araddr1", axi_araddr, 32'h140);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;

        // Interleaved R beats
        for (int k = 0; k < LW-1; k++) begin
            r_beat(0, 32'hB0 + k, 2'b00, 1'b0);
            r_beat(1, 32'hC0 + k, 2'b00, 1'b0);
        end
        r_beat(0, 32'hB7, 2'b00, 1'b1);
        check("ilv_ret_valid0", ret_valid, 2'b01);
        r_beat(1, 32'hC7, 2'b00, 1'b1);
        check("ilv_ret_valid1", ret_valid, 2'b10);
        for (int k = 0; k < LW; k++) begin
            exp0[32*k +: 32] = 32'hB0 + k;
            exp1[32*k +: 32] = 32'hC0 + k;
        end
        check("ilv_data0", ret_data[0 +: 256], exp0);
        check("ilv_data1", ret_data[256 +: 256], exp1);

        // Line write to 0x2000, AW delayed, with hazard and non-hazard reads
        for (int k = 0; k < LW; k++) wr_data[32*k +: 32] = 32'hD0 + k;
        wr_req = 1'b1; wr_type = 1'b1; wr_addr = 32'h2000; wr_wstrb = 4'h3;
        #1;
        check("wr_rdy_idle", wr_rdy, 1'b1);
        tick();
        wr_req = 1'b0;
        check("wr_aw_w_valid", {axi_awvalid, axi_wvalid, wr_rdy}, 3'b110);
        check("wr_shape", {axi_awaddr, axi_awlen, axi_awsize, axi_wstrb}, {32'h2000, 8'd7, 3'd2, 4'hF});
        check("wr_beat0", {axi_wdata, axi_wlast}, {32'hD0, 1'b0});
        rd_type = 2'b01;
        rd_size = 6'b010_010;
        rd_addr = {32'h3000, 32'h201C};
        rd_req  = 2'b11;
        #1;
        check("hazard_rd_rdy", rd_rdy, 2'b10);
        axi_wready = 1'b1;
        tick();
        rd_req = 2'b01;
        for (int k = 1; k < LW; k++) begin
            check("wr_beat", {axi_wdata, axi_wlast, axi_wvalid}, {32'hD0 + k, k == LW-1, 1'b1});
            check("wr_awvalid", axi_awvalid, k <= 5);
            check("wr_rdy_busy", {wr_rdy, rd_rdy[0]}, 2'b00);
            if (k == 1) check("nohaz_araddr", {axi_arvalid, axi_araddr}, {1'b1, 32'h3000});
            axi_arready = (k == 1);
            axi_awready = (k == 5);
            tick();
        end
        axi_wready = 1'b0; axi_awready = 1'b0; axi_arready = 1'b0;
        check("wr_resp", {axi_awvalid, axi_wvalid, axi_bready, wr_rdy, rd_rdy[0]}, 5'b00100);
        r_beat(1, 32'h33, 2'b00, 1'b1);
        check("nohaz_ret", {ret_valid, ret_data[256 +: 64]}, {2'b10, 32'hC1, 32'h33});
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        #1;
        check("wr_ok", {wr_ok, wr_rdy, rd_rdy[0]}, 3'b111);
        rd_req = 2'b00;
        tick();
        check("wr_ok_pulse", wr_ok, 1'b0);

        // Error response, then a clean read clears the flag
        rd_issue(0, 1'b0, 32'h400, 3'd2);
        r_beat(0, 32'h55, 2'b10, 1'b1);
        check("err_set", {ret_valid, ret_err}, {2'b01, 2'b01});
        rd_issue(0, 1'b0, 32'h404, 3'd1);
        check("err_clr_accept", ret_err[0], 1'b0);
        r_beat(0, 32'h66, 2'b00, 1'b1);
        check("err_clean", {ret_valid[0], ret_err[0], ret_data[31:0]}, {1'b1, 1'b0, 32'h66});

        // Reset in the middle of a line read
        rd_issue(1, 1'b1, 32'h5000, 3'd0);
        for (int k = 0; k < 3; k++) r_beat(1, 32'hF0 + k, 2'b00, 1'b0);
        resetn = 1'b0;
        tick();
        check("mid_rst_outs", {ret_valid, ret_err, axi_arvalid, axi_awvalid, axi_wvalid, wr_ok}, '0);
        check("mid_rst_rdy", {rd_rdy, wr_rdy}, 3'b111);
        check("mid_rst_data", ret_data[256 +: 256], '0);
        resetn = 1'b1;
        tick();
        rd_issue(1, 1'b1, 32'h6000, 3'd0);
        for (int k = 0; k < LW; k++) r_beat(1, 32'hE0 + k, 2'b00, k == LW-1);
        for (int k = 0; k < LW; k++) exp1[32*k +: 32] = 32'hE0 + k;
        check("post_rst_valid", ret_valid, 2'b10);
        check("post_rst_data", ret_data[256 +: 256], exp1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Parametrised bridge between the CPU caches and a single AXI3 master port. It replaces the fixed two-read-port converter. The bridge serves NPORT independent read clients with fixed-priority arbitration and one outstanding read per client, identified by AXI ID, with multiple clients in flight at once. It has one write client that drives AW and W concurrently and holds reads that hit the line still being written until its B response returns.

## Interface
- NPORT, 2: number of read clients (1..4); port i uses arid = i.
- LINE_WORDS, 8: words per cache line (power of 2, 2..16); line reads use arlen = LINE_WORDS-1.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- rd_req  in  NPORT  read request per client.
- rd_type  in  NPORT  0 = single word, 1 = full line.
- rd_addr  in  NPORT*32  read address; client i uses bits [32i+:32].
- rd_size  in  NPORT*3  AXI size for single reads.
- rd_rdy  out  NPORT  request accepted this cycle when rd_req & rd_rdy.
- ret_valid  out  NPORT  one-cycle pulse: read data complete.
- ret_err  out  NPORT  any rresp != 0 during the burst; valid with ret_valid.
- ret_data  out  NPORT*LINE_WORDS*32  assembled data; word k at [32k+:32] within the client slice.
- wr_req, wr_type, wr_addr[32], wr_size[3], wr_wstrb[4], wr_data[LINE_WORDS*32]  in  write request fields.
- wr_rdy  out  1  write accepted when wr_req & wr_rdy.
- wr_ok  out  1  one-cycle pulse after the B response.
- axi_ar*, axi_r*, axi_aw*, axi_w*, axi_b*: standard AXI3 master signals. IDs are 4 bits, len 8, size 3, lock 2, cache 4, prot 3.

## Operation
- Constants: arburst = awburst = 2'b01; lock, cache and prot are 0; awid = wid = NPORT.
- Client i is eligible when the AR slot is empty, outstanding[i] = 0 and there is no write hazard.
- rd_rdy[i] = eligible[i] & no lower-index client with rd_req & eligible. rd_rdy depends combinationally on rd_req.
- Read accept latches araddr, arid = i, arlen and arsize into the AR slot.
  - rd_type = 1: arlen = LINE_WORDS-1, arsize = 2.
  - rd_type = 0: arlen = 0, arsize = rd_size.
- Read accept also sets outstanding[i].
- AR slot states: IDLE → SEND on accept; SEND → IDLE on arvalid & arready. arvalid = (state == SEND).
- axi_rready is constant 1.
- R beat with rid = i writes word rcount[i] of the client i buffer, increments rcount[i] and ORs (rresp != 0) into the client's error flag.
- On the rlast beat: rcount[i] clears, outstanding[i] clears, ret_valid[i] pulses next cycle.
- The client i error flag clears on the next read accept for client i.
- ret_data[i] holds its value until the next beat for client i. Single reads land in word 0; upper words keep stale data.
- Write FSM states:
  - IDLE: wr_rdy = 1. Accept latches the request; go to DATA with aw_pend = w_pend = 1.
  - DATA: awvalid = aw_pend, wvalid = w_pend. Each handshake clears its flag. Go to RESP when both flags are clear.
  - RESP: bready = 1. On bvalid, pulse wr_ok next cycle and return to IDLE.
- Write burst shape:
  - wr_type = 1: awlen = LINE_WORDS-1, awsize = 2, wstrb = 4'hF.
  - wr_type = 0: awlen = 0, awsize = wr_size, wstrb = wr_wstrb.
- wdata = word wcount of the latched data. wcount clears on accept and increments on each W handshake. wlast = wvalid & (wcount == awlen).
- Hazard: while the write FSM is not IDLE, a client whose rd_addr[31:LOG2(LINE_WORDS)+2] equals the latched write address in those bits is not eligible.

## Timing
- Read accept at cycle T → arvalid at T+1. Client rd_rdy returns at R+1, where R is the rlast beat; ret_valid also pulses at R+1.
- Write accept at T → awvalid and wvalid at T+1. Back-to-back writes are impossible: the next write can be accepted at B+1, the cycle of wr_ok.
- A W beat may complete before AW; data is not held for AW.
- Read accept and write accept in the same cycle: both proceed; the hazard check uses pre-accept write state.
- bvalid in the same cycle as the final W handshake is ignored; bready is only high in RESP.
- Reset values: all valid/rdy/ok/err outputs are 0 except wr_rdy = 1 and rd_rdy = eligible-derived. All counters, latched fields and outstanding flags are 0.
- Reset mid-burst aborts everything; the AXI slave is reset on the same signal.

## Structure
- Package cache_axi_pkg holds the AXI burst/size constants, the AR and write FSM state encodings, and the LINE_OFF = LOG2(LINE_WORDS)+2 function.
- Sub-module cache_axi_rd_buf is instantiated NPORT times. It contains rcount, the data assembly buffer, the error flag, outstanding and the ret_valid register.

## Test plan
- NPORT = 2, LINE_WORDS = 8. Client 1 line read at 0x1000, slave returns 0xA0..0xA7 → arid = 1, arlen = 7, ret_valid[1] one cycle after rlast, ret_data[1] word k = 0xA0+k.
- Clients 0 and 1 request in the same cycle → client 0 issued first, client 1 issued once the AR slot frees.
- Interleave R beats of ID 0 and ID 1 → both buffers assembled correctly.
- Line write to 0x2000 with AW delayed 5 cycles after W → 8 beats, wlast on beat 8. wr_ok one cycle after bvalid. wr_rdy stays 0 until then.
- Read to 0x201C issued during the 0x2000 write → rd_rdy stays 0 until RESP completes. A read to 0x3000 during the same write proceeds.
- Single read with rresp = 2'b10 → ret_err = 1 with ret_valid. The next read on that client reports ret_err = 0.
- Assert resetn mid line read → all outputs at their reset values next cycle. A fresh read then completes normally.
